vi_sync_edge_filt: RTL

//  Per-bit glitch filter and edge detector on the destination clock. It sits

---
 rtl/vi_sync_edge_filt.sv | 93 +++++++++
 1 files changed

// File: rtl/vi_sync_edge_filt.sv
// Per-bit glitch filter and edge detector on the destination clock domain.
// Optional sticky rise latches are built when VI_SYNC_EDGE_STICKY_EN is defined.
module vi_sync_edge_filt #(
  parameter int SIZE        = 1,
  parameter int FILT_CYCLES = 4,
  localparam int CNT_W      = $clog2(FILT_CYCLES + 1)
) (
  input  logic            clk_dst,
  input  logic            rst_dst,
  input  logic [SIZE-1:0] in_sync,
  output logic [SIZE-1:0] level_out,
  output logic [SIZE-1:0] rise_pulse,
  output logic [SIZE-1:0] fall_pulse,
  output logic            chg_any
`ifdef VI_SYNC_EDGE_STICKY_EN
  ,
  input  logic [SIZE-1:0] sticky_clr,
  output logic [SIZE-1:0] sticky_rise
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt     [SIZE];
  logic [CNT_W-1:0] w_cnt_nxt [SIZE];
  logic [SIZE-1:0]  r_level;
  logic [SIZE-1:0]  r_rise;
  logic [SIZE-1:0]  r_fall;
  logic             r_chg;
  logic [SIZE-1:0]  w_level_nxt;
  logic [SIZE-1:0]  w_rise_nxt;
  logic [SIZE-1:0]  w_fall_nxt;

  // Each bit is STABLE (matches level), PENDING (counting) or ACCEPT (last count).
  always_comb begin
    w_level_nxt = r_level;
    w_rise_nxt  = '0;
    w_fall_nxt  = '0;
    for (int i = 0; i < SIZE; i++) begin
      w_cnt_nxt[i] = '0;
      if (in_sync[i] != r_level[i]) begin
        if (r_cnt[i] == CNT_LAST) begin
          w_level_nxt[i] = in_sync[i];
          w_rise_nxt[i]  = in_sync[i];
          w_fall_nxt[i]  = ~in_sync[i];
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_dst or posedge rst_dst) begin
    if (rst_dst) begin
      for (int i = 0; i < SIZE; i++) begin
        r_cnt[i] <= '0;
      end
      r_level <= '0;
      r_rise  <= '0;
      r_fall  <= '0;
      r_chg   <= 1'b0;
    end else begin
      for (int i = 0; i < SIZE; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
      r_level <= w_level_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
      r_chg   <= |(w_rise_nxt | w_fall_nxt);
    end
  end

  assign level_out  = r_level;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;
  assign chg_any    = r_chg;

`ifdef VI_SYNC_EDGE_STICKY_EN
  logic [SIZE-1:0] r_sticky;

  // Set from the registered pulse, so it lands one cycle later; set beats clear.
  always_ff @(posedge clk_dst or posedge rst_dst) begin
    if (rst_dst) begin
      r_sticky <= '0;
    end else begin
      r_sticky <= (r_sticky & ~sticky_clr) | r_rise;
    end
  end

  assign sticky_rise = r_sticky;
`endif

endmodule
